// File: rtl/wb_bridge_pkg.sv
// rtl/wb_bridge_pkg.sv - shared types and helpers for the Wishbone timeout bridge
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_t;

  // Bits needed to hold any count 0..timeout
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_bridge_timer.sv
// rtl/wb_bridge_timer.sv - access watchdog: counts enabled cycles, flags the last allowed one
module wb_bridge_timer
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  // Count cycles while the access is outstanding; hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/wb_timeout_bridge.sv
// rtl/wb_timeout_bridge.sv - single-outstanding pipelined Wishbone bridge with access timeout (option: WB_BRIDGE_TIMEOUT_STATS_EN)
module wb_timeout_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    s_wb_cyc_i,
  input  logic                    s_wb_stb_i,
  input  logic [ADDR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  output logic                    s_wb_ack_o,
  output logic                    s_wb_err_o,
  output logic                    s_wb_rty_o,
  output logic                    s_wb_stall_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic                    m_wb_cyc_o,
  output logic                    m_wb_stb_o,
  output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
  input  logic                    m_wb_ack_i,
  input  logic                    m_wb_err_i,
  input  logic                    m_wb_rty_i,
  input  logic                    m_wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   m_wb_dat_i
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
  ,
  output logic [15:0]             timeout_cnt_o,
  output logic [ADDR_WIDTH-1:0]   timeout_adr_o
`endif
);

  state_t state;
  rsp_t   rsp_kind;
  logic   req;
  logic   busy;
  logic   rsp_any;
  logic   expired;
  logic   timeout_hit;

  // Decode request, downstream response (err beats rty beats ack) and timeout
  always_comb begin
    req         = s_wb_cyc_i & s_wb_stb_i;
    busy        = (state == ISSUE) || (state == WAIT);
    rsp_any     = m_wb_ack_i | m_wb_err_i | m_wb_rty_i;
    rsp_kind    = RSP_ACK;
    if (m_wb_err_i) begin
      rsp_kind = RSP_ERR;
    end else if (m_wb_rty_i) begin
      rsp_kind = RSP_RTY;
    end
    timeout_hit = busy && s_wb_cyc_i && !rsp_any && expired;
  end

  wb_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .clear   ((state == IDLE) && req),
    .enable  (busy),
    .expired (expired)
  );

  // Bridge FSM; every bus output is a register so upstream sees a clean one-cycle response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      s_wb_ack_o   <= 1'b0;
      s_wb_err_o   <= 1'b0;
      s_wb_rty_o   <= 1'b0;
      s_wb_stall_o <= 1'b0;
      s_wb_dat_o   <= '0;
      m_wb_cyc_o   <= 1'b0;
      m_wb_stb_o   <= 1'b0;
      m_wb_adr_o   <= '0;
      m_wb_sel_o   <= '0;
      m_wb_we_o    <= 1'b0;
      m_wb_dat_o   <= '0;
    end else begin
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      s_wb_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            m_wb_adr_o   <= s_wb_adr_i;
            m_wb_sel_o   <= s_wb_sel_i;
            m_wb_we_o    <= s_wb_we_i;
            m_wb_dat_o   <= s_wb_dat_i;
            m_wb_cyc_o   <= 1'b1;
            m_wb_stb_o   <= 1'b1;
            s_wb_stall_o <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (!s_wb_cyc_i) begin
            // Upstream abandoned the cycle: release downstream silently
            m_wb_cyc_o   <= 1'b0;
            m_wb_stb_o   <= 1'b0;
            s_wb_stall_o <= 1'b0;
            state        <= IDLE;
          end else if (rsp_any) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            s_wb_dat_o <= '0;
            state      <= RESP;
            case (rsp_kind)
              RSP_ERR: s_wb_err_o <= 1'b1;
              RSP_RTY: s_wb_rty_o <= 1'b1;
              default: begin
                s_wb_ack_o <= 1'b1;
                if (!m_wb_we_o) begin
                  s_wb_dat_o <= m_wb_dat_i;
                end
              end
            endcase
          end else if (timeout_hit) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            s_wb_err_o <= 1'b1;
            s_wb_dat_o <= '0;
            state      <= RESP;
          end else if ((state == ISSUE) && !m_wb_stall_i) begin
            m_wb_stb_o <= 1'b0;
            state      <= WAIT;
          end
        end
        RESP: begin
          s_wb_stall_o <= 1'b0;
          s_wb_dat_o   <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
  // Record timeouts: saturating count plus the address that timed out
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timeout_cnt_o <= '0;
      timeout_adr_o <= '0;
    end else if (timeout_hit) begin
      if (timeout_cnt_o != 16'hFFFF) begin
        timeout_cnt_o <= timeout_cnt_o + 16'd1;
      end
      timeout_adr_o <= m_wb_adr_o;
    end
  end
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// tb/tb_wb_timeout_bridge.sv - scoreboard bench for wb_timeout_bridge (option: WB_BRIDGE_TIMEOUT_STATS_EN)
module tb_wb_timeout_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [2:0] K_ACK = 3'b001;
  localparam logic [2:0] K_RTY = 3'b010;
  localparam logic [2:0] K_ERR = 3'b100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [AW-1:0] s_adr = '0;
  logic [3:0]    s_sel = '0;
  logic [DW-1:0] s_dat_w = '0;
  logic          s_ack, s_err, s_rty, s_stall;
  logic [DW-1:0] s_dat_r;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [3:0]    m_sel;
  logic [DW-1:0] m_dat_w;
  logic          m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0, m_stall = 1'b0;
  logic [DW-1:0] m_dat_r = '0;
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
  logic [15:0]   to_cnt;
  logic [AW-1:0] to_adr;
`endif

  wb_timeout_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_wb_cyc_i(s_cyc), .s_wb_stb_i(s_stb), .s_wb_adr_i(s_adr), .s_wb_sel_i(s_sel),
    .s_wb_we_i(s_we), .s_wb_dat_i(s_dat_w),
    .s_wb_ack_o(s_ack), .s_wb_err_o(s_err), .s_wb_rty_o(s_rty), .s_wb_stall_o(s_stall),
    .s_wb_dat_o(s_dat_r),
    .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb), .m_wb_adr_o(m_adr), .m_wb_sel_o(m_sel),
    .m_wb_we_o(m_we), .m_wb_dat_o(m_dat_w),
    .m_wb_ack_i(m_ack), .m_wb_err_i(m_err), .m_wb_rty_i(m_rty), .m_wb_stall_i(m_stall),
    .m_wb_dat_i(m_dat_r)
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
    , .timeout_cnt_o(to_cnt), .timeout_adr_o(to_adr)
`endif
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { logic [2:0] kind; logic [DW-1:0] dat; int at; } up_t;
  typedef struct { logic [AW-1:0] adr; logic [3:0] sel; logic we; logic [DW-1:0] dat; } dn_t;

  up_t up_q[$];
  dn_t dn_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected upstream responses and downstream requests as the DUT presents them
  up_t ue;
  dn_t de;
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ack || s_err || s_rty) begin
        if (up_q.size() == 0) begin
          chk("unexpected_upstream_rsp", {61'd0, s_err, s_rty, s_ack}, 64'd0);
        end else begin
          ue = up_q.pop_front();
          chk("rsp_kind", {61'd0, s_err, s_rty, s_ack}, {61'd0, ue.kind});
          chk("rsp_data", s_dat_r, ue.dat);
          chk("rsp_cycle", cyc_cnt, ue.at);
        end
      end
      if (m_cyc && m_stb && !m_stall) begin
        if (dn_q.size() == 0) begin
          chk("unexpected_downstream_req", {32'd0, m_adr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          de = dn_q.pop_front();
          chk("req_adr", m_adr, de.adr);
          chk("req_sel", m_sel, de.sel);
          chk("req_we", m_we, de.we);
          chk("req_dat", m_dat_w, de.dat);
        end
      end
    end
  end

  // One full transaction; downstream answers 'rsp' (err,rty,ack) delay cycles after the first stb cycle
  task automatic do_txn(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                        input logic [3:0] sel, input int stall_n, input int delay,
                        input logic [2:0] rsp, input logic [DW-1:0] rdat,
                        input logic [2:0] exp_kind, input logic [DW-1:0] exp_dat);
    int t0;
    t0 = cyc_cnt;
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_we = we; s_dat_w = dat; s_sel = sel;
    dn_q.push_back('{adr, sel, we, dat});
    up_q.push_back('{exp_kind, exp_dat, t0 + 2 + delay});
    step();
    s_stb = 1'b0;
    chk("stall_busy", s_stall, 1);
    for (int i = 0; i <= delay; i++) begin
      chk("m_cyc_held", m_cyc, 1);
      m_stall = (i < stall_n);
      if (i == delay) begin
        {m_err, m_rty, m_ack} = rsp;
        m_dat_r = rdat;
      end
      step();
    end
    m_stall = 1'b0; {m_err, m_rty, m_ack} = 3'b000; m_dat_r = '0;
    chk("m_cyc_released", m_cyc, 0);
    s_cyc = 1'b0;
    step();
    chk("stall_idle", s_stall, 0);
  endtask

  // Start a request and park the FSM in WAIT (two cycles after accept)
  task automatic start_to_wait(input logic [AW-1:0] adr);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_we = 1'b0; s_dat_w = '0; s_sel = 4'hF;
    dn_q.push_back('{adr, 4'hF, 1'b0, 32'd0});
    step();
    s_stb = 1'b0;
    step();
    chk("wait_m_cyc", m_cyc, 1);
    chk("wait_m_stb", m_stb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("rst_ctrl", {57'd0, m_cyc, m_stb, m_we, s_ack, s_err, s_rty, s_stall}, 64'd0);
    chk("rst_adr_sel", {28'd0, m_sel, m_adr}, 64'd0);
    chk("rst_dat", {m_dat_w, s_dat_r}, 64'd0);
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
    chk("rst_stats", {16'd0, to_cnt, to_adr}, 64'd0);
`endif
    rst_n = 1'b1;
    step();

    do_txn(32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 0, 2, K_ACK, 32'h0, K_ACK, 32'h0);
    do_txn(32'h0, 1'b0, 32'h0, 4'hF, 0, 0, K_ACK, 32'h15, K_ACK, 32'h15);
    do_txn(32'h10, 1'b0, 32'h0, 4'hF, 2, 4, K_ACK, 32'hA5A50001, K_ACK, 32'hA5A50001);
    do_txn(32'h20, 1'b0, 32'h0, 4'hF, 0, 1, 3'b111, 32'h1234, K_ERR, 32'h0);
    do_txn(32'h24, 1'b1, 32'h55, 4'h3, 0, 0, 3'b011, 32'h0, K_RTY, 32'h0);
    do_txn(32'h28, 1'b1, 32'h66, 4'h1, 0, 1, K_ACK, 32'hFFFF, K_ACK, 32'h0);

    // No downstream answer: err after TO cycles of m_cyc
    do_txn(32'h80, 1'b0, 32'h0, 4'hF, 0, TO - 1, 3'b000, 32'h0, K_ERR, 32'h0);
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
    chk("stats_cnt_timeout", to_cnt, 1);
    chk("stats_adr_timeout", to_adr, 32'h80);
`endif
    // Ack on the expiry cycle wins over the timeout
    do_txn(32'h84, 1'b0, 32'h0, 4'hF, 0, TO - 1, K_ACK, 32'h77, K_ACK, 32'h77);
`ifdef WB_BRIDGE_TIMEOUT_STATS_EN
    chk("stats_cnt_expiry_ack", to_cnt, 1);
    chk("stats_adr_expiry_ack", to_adr, 32'h80);
`endif

    // Upstream abort in WAIT; the simultaneous downstream ack is ignored
    start_to_wait(32'h30);
    s_cyc = 1'b0;
    m_ack = 1'b1; m_dat_r = 32'hBAD;
    step();
    m_ack = 1'b0; m_dat_r = '0;
    chk("abort_m_cyc", m_cyc, 0);
    chk("abort_stall", s_stall, 0);
    step();
    step();
    do_txn(32'h8, 1'b0, 32'h0, 4'hF, 0, 0, K_ACK, 32'h99, K_ACK, 32'h99);

    // Asynchronous reset mid-WAIT
    start_to_wait(32'h40);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {57'd0, m_cyc, m_stb, m_we, s_ack, s_err, s_rty, s_stall}, 64'd0);
    chk("midrst_adr", m_adr, 64'd0);
    s_cyc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_txn(32'hC, 1'b1, 32'h0BADF00D, 4'hF, 0, 1, K_ACK, 32'h0, K_ACK, 32'h0);
    step();

    chk("up_queue_empty", up_q.size(), 0);
    chk("dn_queue_empty", dn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
